// File: rtl/register_bank_8x8.sv
// Eight-entry register bank with one-hot write select and two registered read ports.
// Define REGBANK_BYPASS_EN to forward same-edge write data to a matching read port.
module register_bank_8x8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [2:0]       rd_addr_a,
   input  logic [2:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             sel_err,
   output logic [7:0]       wr_count
);

   logic [WIDTH-1:0] regs [8];
   logic             multi_hot;
   logic             one_hot;
   logic [2:0]       wr_idx;
   logic             byp_a;
   logic             byp_b;

   // Clearing the lowest set bit leaves a non-zero value only when two or more bits are set
   assign multi_hot = (wr_sel & (wr_sel - 8'd1)) != 8'd0;
   assign one_hot   = (wr_sel != 8'd0) && !multi_hot;

   always_comb begin
      wr_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (wr_sel[i]) wr_idx = 3'(i);
      end
   end

`ifdef REGBANK_BYPASS_EN
   assign byp_a = one_hot && (rd_addr_a == wr_idx);
   assign byp_b = one_hot && (rd_addr_b == wr_idx);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         rd_data_a <= '0;
         rd_data_b <= '0;
         sel_err   <= 1'b0;
         wr_count  <= 8'd0;
      end else begin
         if (one_hot) begin
            regs[wr_idx] <= wr_data;
            wr_count     <= wr_count + 8'd1;
         end
         sel_err   <= multi_hot;
         rd_data_a <= byp_a ? wr_data : regs[rd_addr_a];
         rd_data_b <= byp_b ? wr_data : regs[rd_addr_b];
      end
   end

endmodule

// File: tb/tb_register_bank_8x8.sv
// Directed self-checking bench for register_bank_8x8; expectations follow REGBANK_BYPASS_EN.
module tb_register_bank_8x8;

   logic       clk;
   logic       rst;
   logic [7:0] wr_sel;
   logic [7:0] wr_data;
   logic [2:0] rd_addr_a;
   logic [2:0] rd_addr_b;
   logic [7:0] rd_data_a;
   logic [7:0] rd_data_b;
   logic       sel_err;
   logic [7:0] wr_count;

   int vectors;
   int miscompares;

   register_bank_8x8 #(.WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .wr_sel(wr_sel),
      .wr_data(wr_data),
      .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a),
      .rd_data_b(rd_data_b),
      .sel_err(sel_err),
      .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_sel  = 8'h00;
      wr_data = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd0;
      tick();
      tick();
      vectors++;
      if ({rd_data_a, rd_data_b, sel_err, wr_count} !== 25'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got a=%h b=%h err=%b cnt=%h, want all 0",
                  rd_data_a, rd_data_b, sel_err, wr_count);
      end
      rst = 1'b0;
      rd_addr_a = 3'd5;
      rd_addr_b = 3'd6;
      tick();
      vectors++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_unwritten_read: got a=%h b=%h, want 00 00", rd_data_a, rd_data_b);
      end
   endtask

   task automatic test_write_read();
      wr_sel  = 8'h04;
      wr_data = 8'hA5;
      tick();
      idle();
      rd_addr_a = 3'd2;
      tick();
      vectors++;
      if (rd_data_a !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL write_read_r2: got %h, want a5", rd_data_a);
      end
      vectors++;
      if (wr_count !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL write_read_count: got %h, want 01", wr_count);
      end
   endtask

   task automatic test_multi_hot();
      wr_sel  = 8'h01;
      wr_data = 8'h12;
      tick();
      wr_sel  = 8'h05;
      wr_data = 8'hFF;
      tick();
      vectors++;
      if (sel_err !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL multi_hot_err: got %b, want 1", sel_err);
      end
      vectors++;
      if (wr_count !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL multi_hot_count: got %h, want 02", wr_count);
      end
      wr_sel = 8'hC0;
      tick();
      vectors++;
      if (sel_err !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL multi_hot_consecutive: got %b, want 1", sel_err);
      end
      idle();
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd2;
      tick();
      vectors++;
      if (sel_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL zero_sel_err: got %b, want 0", sel_err);
      end
      vectors++;
      if (rd_data_a !== 8'h12 || rd_data_b !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL multi_hot_no_write: got r0=%h r2=%h, want 12 a5", rd_data_a, rd_data_b);
      end
      rd_addr_a = 3'd6;
      rd_addr_b = 3'd7;
      tick();
      vectors++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL multi_hot_r6_r7: got r6=%h r7=%h, want 00 00", rd_data_a, rd_data_b);
      end
   endtask

   task automatic test_bypass();
      logic [7:0] exp_b;
`ifdef REGBANK_BYPASS_EN
      exp_b = 8'h3C;
`else
      exp_b = 8'h11;
`endif
      wr_sel  = 8'h80;
      wr_data = 8'h11;
      tick();
      wr_data   = 8'h3C;
      rd_addr_b = 3'd7;
      tick();
      vectors++;
      if (rd_data_b !== exp_b) begin
         miscompares++;
         $display("[TB] FAIL read_during_write: got %h, want %h", rd_data_b, exp_b);
      end
      vectors++;
      if (wr_count !== 8'd4) begin
         miscompares++;
         $display("[TB] FAIL bypass_count: got %h, want 04", wr_count);
      end
      wr_sel    = 8'h81;
      wr_data   = 8'hEE;
      rd_addr_a = 3'd7;
      tick();
      vectors++;
      if (rd_data_a !== 8'h3C || rd_data_b !== 8'h3C) begin
         miscompares++;
         $display("[TB] FAIL no_bypass_multi_hot: got a=%h b=%h, want 3c 3c", rd_data_a, rd_data_b);
      end
      idle();
      tick();
   endtask

   task automatic test_dual_read();
      wr_sel  = 8'h08;
      wr_data = 8'h5A;
      tick();
      idle();
      rd_addr_a = 3'd3;
      rd_addr_b = 3'd3;
      tick();
      vectors++;
      if (rd_data_a !== 8'h5A || rd_data_b !== 8'h5A) begin
         miscompares++;
         $display("[TB] FAIL dual_read_r3: got a=%h b=%h, want 5a 5a", rd_data_a, rd_data_b);
      end
      vectors++;
      if (wr_count !== 8'd5) begin
         miscompares++;
         $display("[TB] FAIL dual_read_count: got %h, want 05", wr_count);
      end
   endtask

   task automatic test_reset_priority();
      rst       = 1'b1;
      wr_sel    = 8'h01;
      wr_data   = 8'h77;
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd3;
      tick();
      vectors++;
      if ({rd_data_a, rd_data_b, sel_err, wr_count} !== 25'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_priority_outputs: got a=%h b=%h err=%b cnt=%h, want all 0",
                  rd_data_a, rd_data_b, sel_err, wr_count);
      end
      rst = 1'b0;
      idle();
      tick();
      vectors++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || wr_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_priority_regs: got r0=%h r3=%h cnt=%h, want 00 00 00",
                  rd_data_a, rd_data_b, wr_count);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 256; i++) begin
         wr_sel  = 8'h01 << (i % 8);
         wr_data = 8'(i);
         tick();
      end
      idle();
      vectors++;
      if (wr_count !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL wrap_to_zero: got %h, want 00", wr_count);
      end
      wr_sel  = 8'h02;
      wr_data = 8'h99;
      rd_addr_a = 3'd5;
      tick();
      idle();
      vectors++;
      if (wr_count !== 8'h01) begin
         miscompares++;
         $display("[TB] FAIL wrap_next: got %h, want 01", wr_count);
      end
      vectors++;
      if (rd_data_a !== 8'hFD) begin
         miscompares++;
         $display("[TB] FAIL wrap_r5_data: got %h, want fd", rd_data_a);
      end
      rd_addr_b = 3'd1;
      tick();
      vectors++;
      if (rd_data_b !== 8'h99) begin
         miscompares++;
         $display("[TB] FAIL wrap_r1_data: got %h, want 99", rd_data_b);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      wr_sel      = 8'h00;
      wr_data     = 8'h00;
      rd_addr_a   = 3'd0;
      rd_addr_b   = 3'd0;
      test_reset();
      test_write_read();
      test_multi_hot();
      test_bypass();
      test_dual_read();
      test_reset_priority();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/register_bank_8x8.md
REGISTER_BANK_8X8 -- requirements
Module: register_bank_8x8

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each register and of the data ports.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port wr_sel, input, 8: one-hot write select, driven by the 3-to-8 decoder stage (bit n selects register n; all-zero means no write).
REQ-005 SHALL have port wr_data, input, WIDTH: write data.
REQ-006 SHALL have port rd_addr_a, input, 3: read port A register index.
REQ-007 SHALL have port rd_addr_b, input, 3: read port B register index.
REQ-008 SHALL have port rd_data_a, output, WIDTH: registered read data, port A.
REQ-009 SHALL have port rd_data_b, output, WIDTH: registered read data, port B.
REQ-010 SHALL have port sel_err, output, 1: registered flag for an illegal (multi-hot) wr_sel.
REQ-011 SHALL have port wr_count, output, 8: count of committed writes since reset.

Function
REQ-012 SHALL hold eight WIDTH-bit registers R0..R7.
REQ-013 SHALL write wr_data into Rn at the rising edge when wr_sel has exactly bit n set.
REQ-014 SHALL perform no write when wr_sel is 8'h00; sel_err is 0 the following cycle.
REQ-015 SHALL perform no write when wr_sel has two or more bits set.
REQ-016 SHALL drive sel_err high for exactly the cycle following each multi-hot wr_sel; consecutive illegal cycles keep it high continuously.
REQ-017 SHALL register reads with 1-cycle latency: rd_data_a at cycle t+1 equals R[rd_addr_a] sampled at edge t; port B is identical and independent.
REQ-018 SHALL allow both ports to read the same register in the same cycle with identical results.
REQ-019 SHALL resolve read-during-write to the same register per the configuration section (REQ-026/027).
REQ-020 SHALL increment wr_count by 1 on each committed write (REQ-013 only).
REQ-021 SHALL wrap wr_count from 8'hFF to 8'h00 on the next committed write, with no saturation and no flag.
REQ-022 SHALL be a single-state datapath with no stall and no handshake: every cycle accepts a new write and two new reads.

Reset
REQ-023 SHALL, when rst is high at a rising edge, clear R0..R7, rd_data_a, rd_data_b, sel_err and wr_count to 0.
REQ-024 SHALL give rst priority over a write in the same cycle: the write is discarded and wr_count is not incremented.
REQ-025 SHALL resume normal operation at the first edge with rst low; reads issued at that edge return 0 for unwritten registers.

Configuration
REQ-026 SHALL, with macro REGBANK_BYPASS_EN defined, forward wr_data to rd_data_x when rd_addr_x matches the register written at the same edge (new data, 1-cycle latency preserved).
REQ-027 SHALL, without REGBANK_BYPASS_EN, return the pre-write register contents on a same-edge read-during-write; the new value is visible one cycle later.
REQ-028 SHALL apply no bypass for multi-hot or all-zero wr_sel in either build.

Verification
REQ-029 SHALL cover: reset, then wr_sel=8'h04, wr_data=8'hA5, then rd_addr_a=2 -> rd_data_a=8'hA5 one cycle after the read; wr_count=1.
REQ-030 SHALL cover: wr_sel=8'h05, wr_data=8'hFF -> sel_err=1 next cycle; R0 and R2 unchanged; wr_count unchanged.
REQ-031 SHALL cover: wr_sel=8'h80, wr_data=8'h3C, rd_addr_b=7 at the same edge, with R7 previously 8'h11 -> rd_data_b=8'h3C with REGBANK_BYPASS_EN, 8'h11 without it.
REQ-032 SHALL cover: rst=1 together with wr_sel=8'h01, wr_data=8'h77 -> R0=0, wr_count=0, all outputs 0 next cycle.
REQ-033 SHALL cover: 256 consecutive legal writes from reset -> wr_count=8'h00; one more write -> 8'h01.
REQ-034 SHALL cover: rd_addr_a=rd_addr_b=3 with R3=8'h5A -> both read ports return 8'h5A in the same cycle.
